// File: rtl/dds_sweep_ctrl_if.sv
// ============================================================================
// Module      : dds_sweep_ctrl_if
// Description : Config handshake, sweep control and FTW output bundle for
//               the DDS sweep controller. The host/driver side takes the
//               master modport and the controller takes the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dds_sweep_ctrl_if #(
  parameter int FTW_W   = 16,
  parameter int DWELL_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FTW_W-1:0]   cfg_start;
  logic [FTW_W-1:0]   cfg_stop;
  logic [FTW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               go;
  logic               abort;
  logic [FTW_W-1:0]   ftw_out;
  logic               ftw_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, go, abort,
    input  cfg_ready, ftw_out, ftw_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, go, abort,
    output cfg_ready, ftw_out, ftw_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency-sweep scheduler driving the DDS accumulator
//               increment. Steps the FTW from start to stop in step-sized
//               increments, holding each word dwell+1 cycles, clamping the
//               last word to stop.
//               Optional macro SWEEP_LOOP_EN: sweep repeats until abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_ctrl #(
  parameter int FTW_W   = 16,
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  dds_sweep_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [FTW_W-1:0]   start_q, start_d;
  logic [FTW_W-1:0]   stop_q, stop_d;
  logic [FTW_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loaded_q, loaded_d;

  logic               hs;
  logic [FTW_W:0]     sum;
  logic [FTW_W-1:0]   next_ftw;

  // Next-state, next-word and config-capture logic.
  always_comb begin
    hs       = bus.cfg_valid && (state_q == S_IDLE);
    sum      = {1'b0, ftw_q} + {1'b0, step_q};
    // Carry, overshoot or a zero step all land exactly on stop.
    if (sum[FTW_W] || (sum >= {1'b0, stop_q}) || (step_q == '0)) begin
      next_ftw = stop_q;
    end else begin
      next_ftw = sum[FTW_W-1:0];
    end

    state_d  = state_q;
    ftw_d    = ftw_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    loaded_d = loaded_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          start_d  = bus.cfg_start;
          stop_d   = bus.cfg_stop;
          step_d   = bus.cfg_step;
          dwell_d  = bus.cfg_dwell;
          loaded_d = 1'b1;
        end
        // A same-cycle handshake wins over the stored config.
        if (bus.go && (loaded_q || hs)) begin
          ftw_d   = hs ? bus.cfg_start : start_q;
          cnt_d   = hs ? bus.cfg_dwell : dwell_q;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q == '0) begin
          state_d = (ftw_q >= stop_q) ? S_DONE : S_STEP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      S_STEP: begin
        ftw_d   = next_ftw;
        cnt_d   = dwell_q;
        state_d = S_DWELL;
      end
      default: begin
`ifdef SWEEP_LOOP_EN
        ftw_d   = start_q;
        cnt_d   = dwell_q;
        state_d = S_DWELL;
`else
        state_d = S_IDLE;
`endif
      end
    endcase

    // Abort overrides any sweep progress; the current word is held.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ftw_d   = ftw_q;
      cnt_d   = cnt_q;
    end
  end

  // Sweep sequencing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ftw_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured sweep configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.ftw_out   = ftw_q;
  assign bus.done      = (state_q == S_DONE);
`ifdef SWEEP_LOOP_EN
  assign bus.ftw_valid = (state_q != S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
`else
  assign bus.ftw_valid = (state_q == S_DWELL) || (state_q == S_STEP);
  assign bus.busy      = (state_q == S_DWELL) || (state_q == S_STEP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ============================================================================
// Module      : tb_dds_sweep_ctrl
// Description : Scoreboard bench for dds_sweep_ctrl. The driver pushes the
//               expected per-cycle output (valid, done, ftw) for each sweep;
//               a monitor pops and compares on every cycle the DUT shows
//               ftw_valid or done. Honors SWEEP_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_ctrl;

  typedef struct packed {
    logic        v;
    logic        d;
    logic [15:0] f;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];

  dds_sweep_ctrl_if #(.FTW_W(16), .DWELL_W(8)) bus ();

  dds_sweep_ctrl #(.FTW_W(16), .DWELL_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) q.push_back('{v: 1'b1, d: 1'b0, f: f});
  endtask

  task automatic push_done(input logic [15:0] f);
`ifdef SWEEP_LOOP_EN
    q.push_back('{v: 1'b1, d: 1'b1, f: f});
`else
    q.push_back('{v: 1'b0, d: 1'b1, f: f});
`endif
  endtask

  task automatic push_basic_pass();
    push_word(16'd100, 4);
    push_word(16'd110, 4);
    push_word(16'd120, 4);
    push_word(16'd130, 3);
    push_done(16'd130);
  endtask

  // Monitor: every cycle with output activity must match the next expectation.
  always @(negedge clk) begin
    if (bus.ftw_valid || bus.done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got valid=%0b done=%0b ftw=%0h exp no output",
                 bus.ftw_valid, bus.done, bus.ftw_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mon_valid", {31'd0, bus.ftw_valid}, {31'd0, e.v});
        check("mon_done",  {31'd0, bus.done},      {31'd0, e.d});
        check("mon_ftw",   {16'd0, bus.ftw_out},   {16'd0, e.f});
      end
    end
  end

  task automatic load_cfg(input logic [15:0] s, input logic [15:0] p,
                          input logic [15:0] st, input logic [7:0] d, input logic with_go);
    @(negedge clk);
    check("cfg_ready_idle", {31'd0, bus.cfg_ready}, 32'd1);
    bus.cfg_start = s;
    bus.cfg_stop  = p;
    bus.cfg_step  = st;
    bus.cfg_dwell = d;
    bus.cfg_valid = 1'b1;
    bus.go        = with_go;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.go        = 1'b0;
  endtask

  task automatic do_go();
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending exp 0", name, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
    check({name, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_idle_ready"}, {31'd0, bus.cfg_ready}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_stop  = '0;
    bus.cfg_step  = '0;
    bus.cfg_dwell = '0;
    bus.go        = 1'b0;
    bus.abort     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_ready", {31'd0, bus.cfg_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.ftw_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},      32'd0);
    check("rst_done",  {31'd0, bus.done},      32'd0);
    check("rst_ftw",   {16'd0, bus.ftw_out},   32'd0);

`ifdef SWEEP_LOOP_EN
    // Looping sweep: two full passes, then abort during the second done cycle.
    load_cfg(16'd100, 16'd130, 16'd10, 8'd2, 1'b0);
    push_basic_pass();
    push_basic_pass();
    do_go();
    repeat (31) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("loop_abort_valid", {31'd0, bus.ftw_valid}, 32'd0);
    check("loop_abort_busy",  {31'd0, bus.busy},      32'd0);
    check("loop_abort_left",  q.size(), 32'd0);
    q.delete();
`else
    // go before any config: ignored.
    do_go();
    repeat (3) @(negedge clk);
    check("nocfg_busy", {31'd0, bus.busy}, 32'd0);

    // Basic sweep.
    load_cfg(16'd100, 16'd130, 16'd10, 8'd2, 1'b0);
    push_basic_pass();
    do_go();
    wait_drain("basic");

    // Carry clamp.
    load_cfg(16'hFFF0, 16'hFFFF, 16'h0020, 8'd1, 1'b0);
    push_word(16'hFFF0, 3);
    push_word(16'hFFFF, 2);
    push_done(16'hFFFF);
    do_go();
    wait_drain("carry");

    // Zero step clamps straight to stop.
    load_cfg(16'd5, 16'd9, 16'd0, 8'd0, 1'b0);
    push_word(16'd5, 2);
    push_word(16'd9, 1);
    push_done(16'd9);
    do_go();
    wait_drain("step0");

    // start >= stop: one dwell period only.
    load_cfg(16'd50, 16'd20, 16'd1, 8'd3, 1'b0);
    push_word(16'd50, 4);
    push_done(16'd50);
    do_go();
    wait_drain("degen");

    // Handshake and go in the same cycle use the new config.
    push_word(16'd7, 2);
    push_word(16'd8, 1);
    push_done(16'd8);
    load_cfg(16'd7, 16'd8, 16'd5, 8'd0, 1'b1);
    wait_drain("samecyc");

    // Abort on the first cycle of the second word.
    load_cfg(16'd100, 16'd130, 16'd10, 8'd2, 1'b0);
    push_word(16'd100, 4);
    push_word(16'd110, 1);
    do_go();
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_valid", {31'd0, bus.ftw_valid}, 32'd0);
    check("abort_busy",  {31'd0, bus.busy},      32'd0);
    check("abort_ftw",   {16'd0, bus.ftw_out},   32'd110);
    check("abort_left",  q.size(), 32'd0);
    q.delete();
    repeat (3) @(negedge clk);

    // Restart after abort uses the stored config from the start word.
    push_basic_pass();
    do_go();
    wait_drain("restart");

    // Asynchronous reset mid-sweep.
    push_word(16'd100, 2);
    do_go();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.cfg_ready}, 32'd1);
    check("arst_valid", {31'd0, bus.ftw_valid}, 32'd0);
    check("arst_busy",  {31'd0, bus.busy},      32'd0);
    check("arst_ftw",   {16'd0, bus.ftw_out},   32'd0);
    check("arst_left",  q.size(), 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Config was cleared by reset, so go is ignored.
    do_go();
    repeat (3) @(negedge clk);
    check("arst_nocfg_busy", {31'd0, bus.busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS phase-accumulator path. It accepts a sweep configuration (start, stop, step, dwell) through a valid/ready handshake. It then sequences the frequency tuning word (FTW) presented to the accumulator, holding each word for a programmable number of cycles. It sits between the host/config interface and the accumulator's increment input and is the only writer of that increment.

## Interface
- `FTW_W`, default 16: tuning-word width.
- `DWELL_W`, default 8: dwell counter width.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config word set valid.
- `cfg_ready`  out  1  config accepted when `cfg_valid && cfg_ready`.
- `cfg_start`  in  FTW_W  first FTW of sweep.
- `cfg_stop`  in  FTW_W  final FTW of sweep.
- `cfg_step`  in  FTW_W  FTW increment per step.
- `cfg_dwell`  in  DWELL_W  each word held `cfg_dwell+1` cycles.
- `go`  in  1  start sweep (sampled in IDLE only).
- `abort`  in  1  terminate sweep; highest priority after reset.
- `ftw_out`  out  FTW_W  tuning word to accumulator.
- `ftw_valid`  out  1  `ftw_out` is live.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at normal sweep completion.

## Operation
- Reset values: state IDLE, `cfg_ready`=1, `ftw_out`=0, `ftw_valid`=0, `busy`=0, `done`=0, config registers 0, `cfg_loaded`=0.
- States: IDLE, DWELL, STEP, DONE.
- IDLE: `cfg_ready`=1. A handshake captures all four cfg fields and sets `cfg_loaded`. `go` with `cfg_loaded`=1 moves to DWELL with `ftw_out`=start, dwell counter=`cfg_dwell`, `ftw_valid`=1, `busy`=1. `go` with `cfg_loaded`=0 is ignored. A handshake and `go` in the same cycle: the new config is captured and the sweep starts with the new values.
- In every non-IDLE state, `cfg_ready`=0 and config is not captured.
- DWELL: the counter decrements each cycle. At 0, the state moves to DONE if `ftw_out >= stop`, else to STEP.
- STEP (one cycle, `ftw_out` unchanged): compute `sum = {1'b0,ftw_out} + {1'b0,step}` at FTW_W+1 bits. If carry, `sum >= stop`, or `step`=0, then next=`stop`, else next=`sum`. Load `ftw_out`=next, reload the counter, return to DWELL.
- DONE (one cycle): `done`=1, `ftw_valid`=0, `busy`=0, then IDLE. `ftw_out` holds its last value.
- `start >= stop`: the start word is emitted for one dwell period, then DONE. No clamp to stop occurs.
- `abort` in any non-IDLE state: next cycle IDLE, `ftw_valid`=0, `busy`=0, no `done` pulse. `ftw_out` holds. `abort` in IDLE has no effect.
- Reset asserted mid-sweep returns all outputs to reset values immediately; `cfg_loaded` clears.

## Timing
- `go` sampled at edge N: `ftw_out`=start, `ftw_valid`=1 from edge N+1.
- Each word is visible for `cfg_dwell+1` cycles in DWELL, plus 1 STEP cycle before the change, so non-final words persist for `cfg_dwell+2` cycles.
- Final word: `cfg_dwell+1` cycles, then `done` high for exactly one cycle; IDLE on the following edge.
- Total sweep with K words: K·(dwell+1) + (K−1) + 1 cycles from the first `ftw_valid` to the end of `done`.
- `abort` at edge M: `ftw_valid`=0 from edge M+1.

## Configuration
- `SWEEP_LOOP_EN` defined: DONE does not return to IDLE. It pulses `done`, then reloads `ftw_out`=start and re-enters DWELL on the next edge. `ftw_valid` and `busy` stay 1 through the wrap; `done` pulses once per pass. Only `abort` or reset ends the sweep.
- Undefined: single-shot behaviour as above.

## Test plan
- Reset: drive `reset`=0 mid-sweep -> all outputs 0 and `cfg_ready`=1 asynchronously, before the next clock edge.
- Basic sweep: start=100, stop=130, step=10, dwell=2 -> `ftw_out` 100,110,120,130, each held 3 cycles with 1 STEP cycle between; `done` 1 cycle; 15 cycles `ftw_valid` high.
- Clamp/overflow: FTW_W=16, start=0xFFF0, stop=0xFFFF, step=0x20 -> 0xFFF0 then 0xFFFF (carry clamps), `done`. Also step=0 with start=5, stop=9 -> 5 then 9.
- Degenerate: start=50, stop=20 -> only 50 for dwell+1 cycles, then `done`. `go` before any config -> no response, `busy` stays 0.
- Abort: abort during second word of the basic sweep -> `ftw_valid`=0 the next cycle, no `done`. A new `go` restarts at 100.
- Loop (`SWEEP_LOOP_EN`): basic sweep -> sequence 100..130 repeats with `done` per pass and `ftw_valid` never dropping, until `abort`.
